// File: rtl/uart_regif.sv
// UART register file with TX/RX byte FIFOs and interrupts.
// Single-pulse request bus in, one-cycle registered ack out.
module uart_regif #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd868
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mreq_i,
  input  logic [ADDR_WIDTH-1:0] maddr_i,
  input  logic                  mwe_i,
  input  logic [DATA_WIDTH-1:0] mwdata_i,
  input  logic [3:0]            mstrb_i,
  output logic                  mack_o,
  output logic [DATA_WIDTH-1:0] mrdata_o,
  output logic                  mresp_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  tx_en_o,
  output logic                  rx_en_o,
  output logic                  parity_en_o,
  output logic                  parity_odd_o,
  output logic                  stop2_o,
  output logic [31:0]           clk_div_o,
  output logic                  irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [4:0]  ctrl;
  logic [31:0] clk_div;
  logic [4:0]  int_en;
  logic [2:0]  sticky;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_cnt;

  logic unused_addr;
  assign unused_addr = ^maddr_i;

  logic [4:0] off;
  logic [2:0] idx;
  logic       acc, wr, rd;
  assign off = maddr_i[4:0];
  assign idx = off[4:2];
  assign acc = mreq_i & (off[1:0] == 2'b00);
  assign wr  = mwe_i;
  assign rd  = ~mwe_i;

  logic sel_ctrl, sel_div, sel_stat, sel_txd;
  logic sel_rxd, sel_ien, sel_ist, sel_bad;
  assign sel_ctrl = acc & (idx == 3'd0);
  assign sel_div  = acc & (idx == 3'd1);
  assign sel_stat = acc & (idx == 3'd2);
  assign sel_txd  = acc & (idx == 3'd3);
  assign sel_rxd  = acc & (idx == 3'd4);
  assign sel_ien  = acc & (idx == 3'd5);
  assign sel_ist  = acc & (idx == 3'd6);
  assign sel_bad  = mreq_i & ~(acc & (idx != 3'd7));

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL);
  assign rx_empty = (rx_cnt == '0);

  logic tx_flush, tx_pop, tx_push_req, tx_push, tx_ovf;
  assign tx_flush    = sel_ctrl & wr & mstrb_i[1] & mwdata_i[8];
  assign tx_pop      = tx_valid_o & tx_ready_i;
  assign tx_push_req = sel_txd & wr & mstrb_i[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf      = tx_push_req & ~tx_push;

  logic rx_flush, rx_rd, rx_pop, rx_unf, rx_push, rx_ovr;
  assign rx_flush = sel_ctrl & wr & mstrb_i[1] & mwdata_i[9];
  assign rx_rd    = sel_rxd & rd;
  assign rx_pop   = rx_rd & ~rx_empty;
  assign rx_unf   = rx_rd & rx_empty;
  assign rx_push  = rx_valid_i & (~rx_full | rx_pop);
  assign rx_ovr   = rx_valid_i & ~rx_push;

  logic [4:0]  int_stat;
  logic [31:0] status;
  logic [2:0]  w1c;
  assign int_stat = {~rx_empty, tx_empty, sticky};
  assign status   = {12'd0, rx_empty, rx_full, tx_empty, tx_full,
                     8'(rx_cnt), 8'(tx_cnt)};
  assign w1c = (sel_ist & wr & mstrb_i[0]) ? mwdata_i[2:0] : 3'b000;

  logic [31:0] rdata_d;
  logic        resp_d;

  always_comb begin
    rdata_d = '0;
    resp_d  = 1'b0;
    unique case (1'b1)
      sel_ctrl: if (rd) rdata_d = {27'd0, ctrl};
      sel_div:  if (rd) rdata_d = clk_div;
      sel_stat: if (rd) rdata_d = status;
                else    resp_d  = 1'b1;
      sel_txd:  resp_d = tx_ovf;
      sel_rxd: begin
        if (rd) begin
          resp_d = rx_unf;
          if (!rx_unf) rdata_d = {24'd0, rx_mem[rx_rptr]};
        end else begin
          resp_d = 1'b1;
        end
      end
      sel_ien:  if (rd) rdata_d = {27'd0, int_en};
      sel_ist:  if (rd) rdata_d = {27'd0, int_stat};
      sel_bad:  resp_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr] <= mwdata_i[7:0];
    if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mack_o   <= 1'b0;
      mrdata_o <= '0;
      mresp_o  <= 1'b0;
      irq_o    <= 1'b0;
      ctrl     <= '0;
      clk_div  <= DEFAULT_DIV;
      int_en   <= '0;
      sticky   <= '0;
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_cnt   <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_cnt   <= '0;
    end else begin
      mack_o   <= mreq_i;
      mrdata_o <= rdata_d;
      mresp_o  <= resp_d;
      irq_o    <= |(int_stat & int_en);
      if (sel_ctrl & wr & mstrb_i[0]) ctrl <= mwdata_i[4:0];
      for (int b = 0; b < 4; b++) begin
        if (sel_div & wr & mstrb_i[b])
          clk_div[b*8 +: 8] <= mwdata_i[b*8 +: 8];
      end
      if (sel_ien & wr & mstrb_i[0]) int_en <= mwdata_i[4:0];
      // a same-cycle set beats the clear
      sticky <= (sticky & ~w1c) | {rx_unf, tx_ovf, rx_ovr};
      if (tx_flush) begin
        tx_wptr <= '0;
        tx_rptr <= '0;
        tx_cnt  <= '0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + AW'(1);
        if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
        tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end
      if (rx_flush) begin
        rx_wptr <= '0;
        rx_rptr <= '0;
        rx_cnt  <= '0;
      end else begin
        if (rx_push) rx_wptr <= rx_wptr + AW'(1);
        if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
        rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      end
    end
  end

  assign tx_data_o    = tx_mem[tx_rptr];
  assign tx_valid_o   = ~tx_empty;
  assign tx_en_o      = ctrl[0];
  assign rx_en_o      = ctrl[1];
  assign parity_en_o  = ctrl[2];
  assign parity_odd_o = ctrl[3];
  assign stop2_o      = ctrl[4];
  assign clk_div_o    = clk_div;
endmodule

// File: doc/uart_regif.md
Name: uart_regif

Overview:
Register file and FIFO block that consumes the single-pulse memory-request bus produced by the APB-to-memory bridge. It answers each request with a one-cycle acknowledge plus read data and an error flag. It holds the UART control and divisor configuration, a TX FIFO feeding the serializer, an RX FIFO filled by the deserializer, and interrupt status/enable with a registered IRQ.

Parameters:
ADDR_WIDTH, 32, width of maddr_i; only bits [4:0] are decoded, upper bits are ignored.
DATA_WIDTH, 32, bus data width; fixed at 32.
FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, 2..128.
DEFAULT_DIV, 868, reset value of CLK_DIV.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous reset, active-high.
mreq_i  in  1  request pulse; one cycle per transfer.
maddr_i  in  ADDR_WIDTH  byte address.
mwe_i  in  1  1 = write.
mwdata_i  in  32  write data.
mstrb_i  in  4  write byte strobes.
mack_o  out  1  acknowledge; one-cycle pulse.
mrdata_o  out  32  read data; valid with mack_o.
mresp_o  out  1  error; valid with mack_o.
tx_data_o  out  8  TX FIFO head.
tx_valid_o  out  1  TX FIFO not empty.
tx_ready_i  in  1  serializer pops the head when valid & ready.
rx_data_i  in  8  received byte.
rx_valid_i  in  1  push strobe; no backpressure.
tx_en_o, rx_en_o, parity_en_o, parity_odd_o, stop2_o  out  1 each  CTRL bits [4:0].
clk_div_o  out  32  CLK_DIV register.
irq_o  out  1  interrupt, registered.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - mack_o, mresp_o, irq_o = 0; mrdata_o = 0.
  - CTRL = 0; CLK_DIV = DEFAULT_DIV; INT_EN = 0; sticky INT_STAT bits = 0.
  - Both FIFOs emptied; tx_valid_o = 0.
  - A request in flight is dropped: no ack is issued.
- Latency: mreq_i in cycle N → mack_o=1 in cycle N+1 only, with mrdata_o/mresp_o from the same registers. All register side effects commit at the edge ending cycle N.
  - mrdata_o = 0 whenever mack_o=0 or the access is a write.
- Decode uses maddr_i[4:0]. maddr_i[1:0] != 0 or an unmapped offset → mresp=1, no effect, read data 0.
- Register map:
  - 0x00 CTRL, RW.
    - bits [4:0] = tx_en, rx_en, parity_en, parity_odd, stop2.
    - bit 8 TX flush, bit 9 RX flush: write-1 self-clearing, read as 0.
  - 0x04 CLK_DIV, RW, 32 bits, per-byte strobes.
  - 0x08 STATUS, RO.
    - [7:0] tx_count, [15:8] rx_count.
    - 16 tx_full, 17 tx_empty, 18 rx_full, 19 rx_empty.
  - 0x0C TXD, WO.
    - Write with mstrb_i[0]=1 pushes mwdata_i[7:0].
    - mstrb_i[0]=0 → no push, no error.
    - Read returns 0, mresp=0.
  - 0x10 RXD, RO.
    - Read pops the head; data in [7:0].
    - Read when empty → data 0, mresp=1, sticky rx_underrun set.
  - 0x14 INT_EN, RW, bits [4:0].
  - 0x18 INT_STAT.
    - bit 0 rx_overrun, bit 1 tx_overflow, bit 2 rx_underrun: sticky, W1C.
    - bit 3 tx_empty, bit 4 rx_not_empty: live levels; writes ignored.
- Write strobes apply per byte to RW registers. A write to a RO register (STATUS, RXD) → mresp=1, no effect.
- TX FIFO:
  - TXD write when full → byte dropped, mresp=1, tx_overflow set.
  - Push and pop in the same cycle → count unchanged, both take effect. When full, the push is accepted if a pop occurs in the same cycle.
  - Flush in the same cycle as a push or pop → flush wins; FIFO empty next cycle.
- RX FIFO:
  - rx_valid_i when full and no simultaneous RXD pop → byte dropped, rx_overrun set.
  - Same-cycle push/pop when full → accepted.
  - RX flush wins over push and pop.
- Sticky bits: W1C in the same cycle as a new set event → the bit stays set.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
- irq_o is registered: irq_o(t+1) = |(INT_STAT[4:0] & INT_EN[4:0]) evaluated at t.
- tx_en_o/rx_en_o do not gate the FIFOs; they are configuration outputs only.

Test Plan:
- After reset → CLK_DIV read = 0x0000_0364, CTRL = 0, STATUS = 0x000A_0000, irq_o = 0. Each mreq_i pulse gives exactly one mack_o pulse one cycle later.
- CLK_DIV: write 0xAABBCCDD with strb 0xF, then write 0x11223344 with strb 0x5 → read 0xAA22CC44, clk_div_o matches.
- TX FIFO fill and overflow:
  - Write TXD 16 times (bytes 0x00..0x0F) with tx_ready_i=0 → tx_count 16, tx_full=1.
  - 17th write → mresp=1, INT_STAT bit 1 set.
  - Hold tx_ready_i=1 → tx_data_o sequence 0x00..0x0F, then tx_valid_o=0.
- RX FIFO overrun and underrun:
  - Push 17 bytes 0xA0..0xB0 → INT_STAT bit 0 set.
  - Reads return 0xA0..0xAF with mresp=0.
  - 17th read → data 0, mresp=1, bit 2 set.
  - Write INT_STAT 0x7 → reads 0x8 (tx_empty only).
- Simultaneous events:
  - RX full + rx_valid_i and RXD read in the same cycle → no overrun, rx_count stays 16.
  - TX flush write in the same cycle as a tx pop → tx_count 0 next cycle.
- Interrupts and reset:
  - INT_EN=0x10, push one RX byte → irq_o rises 2 cycles after push.
  - Pulse rst_i while mreq_i=1 → no mack_o, all outputs at reset values.
  - Misaligned address 0x06 → mresp=1.
